// File: rtl/fwd_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// fwd_hazard_scoreboard
//   Shift-register scoreboard of in-flight register writers (EX..WB). For every
//   source operand in ID it yields either a forwarding select (stage whose
//   output already holds the value) or a stall when the youngest writer has not
//   yet produced its result.
//
//   Optional feature macro: FWD_STATS_EN (adds stall_cnt_o, saturating count of
//   unheld stall cycles).
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   id_valid_i        valid instruction in ID
//   id_src_addr_i     packed source addresses, src i at [i*REG_AW +: REG_AW]
//   id_src_use_i      per-src "operand actually read"
//   id_wen_i          ID instruction writes a register
//   id_dst_addr_i     ID destination register
//   id_rdy_stg_i      stage whose output first holds the result
//   hold_i            global freeze, no shift
//   flush_i           kill ID instruction
//   stall_o           hold ID/IF, bubble into EX
//   fwd_sel_o         per src: 0 = regfile, k = forward from stage k
//   stall_cnt_o       (FWD_STATS_EN only) saturating stall-cycle counter
// ---------------------------------------------------------------------------

// Per-operand match against the scoreboard. The youngest matching entry
// (lowest stage index) decides between forward and stall.
module fwd_hazard_src_chk #(
   parameter int NUM_STG = 3,
   parameter int REG_AW  = 5,
   parameter int SEL_W   = 2
) (
   input  logic                           i_en,
   input  logic [REG_AW-1:0]              i_src,
   input  logic [NUM_STG:1]               i_vld,
   input  logic [NUM_STG:1][REG_AW-1:0]   i_dst,
   input  logic [NUM_STG:1][SEL_W-1:0]    i_rdy,
   output logic [SEL_W-1:0]               o_sel,
   output logic                           o_stall
);

   // Walk oldest -> youngest so a younger match overrides an older one.
   always_comb begin
      o_sel   = '0;
      o_stall = 1'b0;
      for (int k = NUM_STG; k >= 1; k--) begin
         if (i_en && (i_src != '0) && i_vld[k] && (i_dst[k] == i_src)) begin
            if (k >= int'(i_rdy[k])) begin
               o_sel   = SEL_W'(k);
               o_stall = 1'b0;
            end else begin
               o_sel   = '0;
               o_stall = 1'b1;
            end
         end
      end
   end

endmodule

module fwd_hazard_scoreboard #(
   parameter  int NUM_SRC = 2,
   parameter  int NUM_STG = 3,
   parameter  int REG_AW  = 5,
   localparam int SEL_W   = $clog2(NUM_STG+1)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       id_valid_i,
   input  logic [NUM_SRC*REG_AW-1:0]  id_src_addr_i,
   input  logic [NUM_SRC-1:0]         id_src_use_i,
   input  logic                       id_wen_i,
   input  logic [REG_AW-1:0]          id_dst_addr_i,
   input  logic [SEL_W-1:0]           id_rdy_stg_i,
   input  logic                       hold_i,
   input  logic                       flush_i,
   output logic                       stall_o,
   output logic [NUM_SRC*SEL_W-1:0]   fwd_sel_o
`ifdef FWD_STATS_EN
  ,output logic [31:0]                stall_cnt_o
`endif
);

   // Scoreboard, index = stage (1 = EX .. NUM_STG = WB)
   logic [NUM_STG:1]               r_vld_pipe;
   logic [NUM_STG:1][REG_AW-1:0]   r_dst;
   logic [NUM_STG:1][SEL_W-1:0]    r_rdy;

   logic [NUM_SRC-1:0]             w_src_stall;
   logic [SEL_W-1:0]               w_rdy_n;
   logic                           w_ins;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      fwd_hazard_src_chk #(
         .NUM_STG (NUM_STG),
         .REG_AW  (REG_AW),
         .SEL_W   (SEL_W)
      ) u_chk (
         .i_en    (id_valid_i & id_src_use_i[i]),
         .i_src   (id_src_addr_i[i*REG_AW +: REG_AW]),
         .i_vld   (r_vld_pipe),
         .i_dst   (r_dst),
         .i_rdy   (r_rdy),
         .o_sel   (fwd_sel_o[i*SEL_W +: SEL_W]),
         .o_stall (w_src_stall[i])
      );
   end

   // A killed instruction never stalls.
   assign stall_o = (|w_src_stall) & ~flush_i;

   // Clamp ready stage into 1..NUM_STG.
   always_comb begin
      w_rdy_n = id_rdy_stg_i;
      if (id_rdy_stg_i == '0)
         w_rdy_n = SEL_W'(1);
      else if (int'(id_rdy_stg_i) > NUM_STG)
         w_rdy_n = SEL_W'(NUM_STG);
   end

   assign w_ins = id_valid_i & id_wen_i & (id_dst_addr_i != '0) & ~stall_o & ~flush_i;

   // Oldest entry simply falls off: by then the regfile already holds it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld_pipe <= '0;
         r_dst      <= '0;
         r_rdy      <= '0;
      end else if (!hold_i) begin
         for (int k = NUM_STG; k >= 2; k--) begin
            r_vld_pipe[k] <= r_vld_pipe[k-1];
            r_dst[k]      <= r_dst[k-1];
            r_rdy[k]      <= r_rdy[k-1];
         end
         r_vld_pipe[1] <= w_ins;
         r_dst[1]      <= id_dst_addr_i;
         r_rdy[1]      <= w_rdy_n;
      end
   end

`ifdef FWD_STATS_EN
   logic [31:0] r_stall_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_stall_cnt <= '0;
      else if (!hold_i && stall_o && (r_stall_cnt != 32'hFFFF_FFFF))
         r_stall_cnt <= r_stall_cnt + 32'd1;
   end

   assign stall_cnt_o = r_stall_cnt;
`endif

endmodule
